instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  the field bundle is valid.
REQ-005 in_ready  output  1  the block can accept a bundle this cycle.
REQ-006 op  input  7  RV32I opcode field.
REQ-007 rd, rs1, rs2  input  5 each  register indices.
REQ-008 funct3  input  3; funct7  input  7  function fields.
REQ-009 imm  input  32  signed immediate, unscaled byte offset for branches and jumps.
REQ-010 out_valid  output  1  inst is valid.
REQ-011 out_ready  input  1  the consumer accepts inst this cycle.
REQ-012 inst  output  32  encoded instruction word.
REQ-013 out_err  output  1  error flag for the word currently on inst.
REQ-014 count  output  16  number of bundles accepted since reset; wraps at 0xFFFF to 0.

Function
REQ-015 The block SHALL accept a bundle on a rising edge when in_valid and in_ready are both 1 (push).
REQ-016 The block SHALL encode a pushed bundle combinationally and write it into a 2-entry FIFO that holds {inst, out_err}.
REQ-017 Latency: a bundle pushed at edge N SHALL appear with out_valid=1 after edge N, when the FIFO was empty.
REQ-018 The block SHALL pop the head entry on an edge when out_valid and out_ready are both 1; FIFO order SHALL be preserved.
REQ-019 in_ready SHALL equal (occupancy<2) and SHALL depend on registers only.
  - When the FIFO is full and a pop occurs, no push is accepted that cycle.
  - in_ready SHALL rise on the following cycle.
REQ-020 out_valid SHALL equal (occupancy>0).
REQ-021 On a simultaneous push and pop with occupancy 1, occupancy SHALL stay 1 and the new word SHALL become the head.
REQ-022 A push SHALL increment count; a pop SHALL NOT change count.
REQ-023 R-type, op=0110011: the encoded word SHALL be {funct7, rs2, rs1, funct3, rd, op}.
REQ-024 I-type, op=0010011/0000011/1100111: the encoded word SHALL be {imm[11:0], rs1, funct3, rd, op}.
  - For op=1100111, funct3 is forced to 000.
  - For op=0010011 with funct3=001/101, the word SHALL be {funct7, imm[4:0], rs1, funct3, rd, op}.
REQ-025 S-type, op=0100011: the encoded word SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
REQ-026 B-type, op=1100011: the encoded word SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
REQ-027 U-type, op=0110111/0010111: the encoded word SHALL be {imm[31:12], rd, op}.
REQ-028 J-type, op=1101111: the encoded word SHALL be {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-029 The block SHALL apply these range checks; any violation is an error:
  - I/S: imm[31:11] all equal.
  - Shift: imm[31:5]==0.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
REQ-030 On an error or an unsupported op, the block SHALL store inst=0x00000013 (NOP) with out_err=1; otherwise out_err=0.
REQ-031 The block SHALL ignore in_valid while in_ready=0 and SHALL leave the FIFO contents unchanged.

Reset
REQ-032 While rst=1, the block SHALL hold out_valid=0, count=0, occupancy=0, inst=0x00000000, out_err=0 and in_ready=0, regardless of clk.
REQ-033 On the first edge after rst falls, in_ready SHALL be 1.
REQ-034 Reset mid-operation SHALL discard all FIFO entries, and no partial word SHALL be emitted afterwards.

Verification
REQ-035 addi x1,x0,5 (op=0010011, rd=1, rs1=0, f3=0, imm=5), out_ready=1 -> inst=0x00500093, out_err=0, one cycle later, count=1.
REQ-036 sw x2,8(x1) (op=0100011, rs1=1, rs2=2, f3=010, imm=8) -> inst=0x0020A423, out_err=0.
REQ-037 jal x1,+2048 (op=1101111, rd=1, imm=0x800) -> inst=0x001000EF; beq with imm=3 -> inst=0x00000013, out_err=1.
REQ-038 Backpressure: out_ready=0 and three pushes of addi imm=1,2,3 -> in_ready=0 after the second push.
  - Then out_ready=1 -> words with imm 1,2,3 emerge in order, and count=3.
REQ-039 Reset with 2 entries queued -> out_valid=0 and count=0 immediately without a clock edge; after release, in_ready=1.
REQ-040 addi with imm=0x800 -> inst=0x00000013, out_err=1; lui with imm=0x12345000, rd=5 -> inst=0x123452B7.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the RV32I instruction encoder.
// The master side produces bundles and consumes words; the slave side is the encoder.
interface instr_encoder_if;
    logic               in_valid;
    logic               in_ready;
    logic [6:0]         op;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        inst;
    logic               out_err;
    logic [15:0]        count;

    modport master (
        output in_valid, op, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, inst, out_err, count
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, inst, out_err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field bundles into 32-bit words and queues
// {inst, out_err} in a 2-entry FIFO; out-of-range immediates become a flagged NOP.
module instr_encoder (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus
);
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    // Returns {err, word}; any rejected bundle collapses to the canonical NOP.
    function automatic logic [32:0] encode(
        input logic [6:0]         op,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        logic        err;
        logic        i_ok;
        logic        b_ok;
        logic        j_ok;
        w    = NOP;
        err  = 1'b0;
        i_ok = (&imm[31:11]) | ~(|imm[31:11]);
        b_ok = (&imm[31:12]) | ~(|imm[31:12]);
        j_ok = (&imm[31:20]) | ~(|imm[31:20]);
        case (op)
            OP_R: w = {f7, rs2, rs1, f3, rd, op};
            OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    w   = {f7, imm[4:0], rs1, f3, rd, op};
                    err = |imm[31:5];
                end else begin
                    w   = {imm[11:0], rs1, f3, rd, op};
                    err = ~i_ok;
                end
            end
            OP_LOAD: begin
                w   = {imm[11:0], rs1, f3, rd, op};
                err = ~i_ok;
            end
            OP_JALR: begin
                w   = {imm[11:0], rs1, 3'b000, rd, op};
                err = ~i_ok;
            end
            OP_STORE: begin
                w   = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                err = ~i_ok;
            end
            OP_BRANCH: begin
                w   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                err = ~b_ok | imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                w   = {imm[31:12], rd, op};
                err = |imm[11:0];
            end
            OP_JAL: begin
                w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                err = ~j_ok | imm[0];
            end
            default: err = 1'b1;
        endcase
        if (err) w = NOP;
        return {err, w};
    endfunction

    logic [32:0] enc_p0;
    logic        vld_p0;
    logic        pop;

    logic [31:0] mem_inst_p1 [2];
    logic        mem_err_p1  [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic        rdy_q;
    logic [15:0] cnt;

    // Stage p0: combinational encode of the offered bundle.
    assign enc_p0 = encode(bus.op, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.imm);
    assign vld_p0 = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;

    // rdy_q keeps in_ready low throughout reset and until the first edge after it.
    assign bus.in_ready  = rdy_q & (occ != 2'd2);
    assign bus.out_valid = (occ != 2'd0);
    assign bus.inst      = bus.out_valid ? mem_inst_p1[rd_ptr] : 32'h0;
    assign bus.out_err   = bus.out_valid ? mem_err_p1[rd_ptr]  : 1'b0;
    assign bus.count     = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q  <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            cnt    <= 16'd0;
        end else begin
            rdy_q <= 1'b1;
            if (vld_p0) begin
                wr_ptr <= ~wr_ptr;
                cnt    <= cnt + 16'd1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({vld_p0, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Stage p1: FIFO storage; visibility is governed by occ, so no reset is needed.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem_inst_p1[wr_ptr] <= enc_p0[31:0];
            mem_err_p1[wr_ptr]  <= enc_p0[32];
        end
    end
endmodule
